// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for two requesters in front of the single-ported data_mem.
// It runs one transaction at a time and has a read timeout so a missing rd_ack cannot stall it.
//
// state   | meaning
// IDLE    | sample requests, grant one port, latch its command
// ISSUE   | drive data_mem: write commits and acks here, read pulses stb
// WAIT_RD | wait for rd_ack or the timeout
// RESP    | return read data / error to the granted port
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_wr0,
  input  logic                  i_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_err,
  output logic                  o_mem_stb,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err_q, err_d;
  logic                  stb_q, stb_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  pick;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      stb_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      stb_q      <= stb_d;
      wr_en_q    <= wr_en_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    pick       = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    stb_d      = 1'b0;
    wr_en_d    = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          pick       = (i_req0 && i_req1) ? ~last_gnt_q : i_req1;
          gnt_d      = pick;
          last_gnt_d = pick;
          wr_d       = pick ? i_wr1 : i_wr0;
          addr_d     = pick ? i_addr1 : i_addr0;
          wdata_d    = pick ? i_wdata1 : i_wdata0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = '0;
        end
      end
      WAIT_RD: begin
        if (i_mem_rd_ack) begin
          resp_data = i_mem_rdata;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_err = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    if (state_d == ISSUE) begin
      stb_d   = ~wr_d;
      wr_en_d = wr_d;
      if (wr_d) begin
        ack0_d = ~gnt_d;
        ack1_d = gnt_d;
      end
    end
    if (state_d == RESP) begin
      ack0_d = ~gnt_d;
      ack1_d = gnt_d;
      err_d  = resp_err;
      if (gnt_d) rdata1_d = resp_data;
      else       rdata0_d = resp_data;
    end
  end

  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_err       = err_q;
  assign o_mem_stb   = stb_q;
  assign o_mem_wr_en = wr_en_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 1-cycle data_mem model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_stb, mem_wr_en, mem_rd_ack;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic        no_ack = 1'b0;
  logic        spur = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] rdat_r = '0;
  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1), .o_err(err),
    .o_mem_stb(mem_stb), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rd_ack(mem_rd_ack), .i_mem_rdata(mem_rdata)
  );

  // data_mem model: 1-cycle read latency, word index from addr[7:2]
  always @(posedge clk) begin
    ack_r <= 1'b0;
    if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_stb && !no_ack) begin
      ack_r  <= 1'b1;
      rdat_r <= mem[mem_addr[7:2]];
    end
  end
  assign mem_rd_ack = ack_r | spur;
  assign mem_rdata  = rdat_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{ack0, ack1, err, mem_stb, mem_wr_en, mem_addr, mem_wdata, rdata0, rdata1};
  endfunction

  // Issue one transaction from the IDLE cycle; returns ack latency (-1 on budget expiry).
  task automatic xact(input int port, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic er, output logic [1:0] s1);
    lat = -1; rd = '0; er = 1'b0; s1 = 2'b00;
    if (port == 0) begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wd; end
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) s1 = {mem_stb, mem_wr_en};
      if ((port == 0) ? ack0 : ack1) begin
        lat = i;
        rd  = (port == 0) ? rdata0 : rdata1;
        er  = err;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  initial begin
    int          lat, n, n0, n1, simul, first, first_c, last_c, cnt_a;
    int          seq [8];
    logic [31:0] rd;
    logic        er, got0, got1;
    logic [1:0]  s1;

    // reset state
    step(); step();
    check("rst_outputs", any_out(), 0);
    rst_n = 1'b1;
    step();
    check("idle_outputs", any_out(), 0);

    // 1: port 0 write then read
    xact(0, 1'b1, 32'd32, 32'd1234, lat, rd, er, s1);
    check("t1_wr_lat", lat, 1);
    check("t1_wr_strobes", s1, 2'b01);
    xact(0, 1'b0, 32'd32, 32'd0, lat, rd, er, s1);
    check("t1_rd_lat", lat, 3);
    check("t1_rd_strobes", s1, 2'b10);
    check("t1_rd_data", rd, 1234);
    check("t1_rd_err", er, 0);

    // preload 5678 at 16 through port 1
    xact(1, 1'b1, 32'd16, 32'd5678, lat, rd, er, s1);
    check("pre_wr1_lat", lat, 1);

    // 2: simultaneous reads right after reset
    rst_n = 1'b0;
    #3;
    check("t2_rst_outputs", any_out(), 0);
    step();
    rst_n = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd16;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'd32;
    got0 = 1'b0; got1 = 1'b0; simul = 0; first = -1;
    for (int i = 0; i < 30 && !(got0 && got1); i++) begin
      step();
      if (ack0 && ack1) simul++;
      if (ack0) begin got0 = 1'b1; req0 = 1'b0; if (first < 0) first = 0; end
      if (ack1) begin got1 = 1'b1; req1 = 1'b0; if (first < 0) first = 1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t2_both_done", {got0, got1}, 2'b11);
    check("t2_first_port", first, 0);
    check("t2_rdata0", rdata0, 5678);
    check("t2_rdata1", rdata1, 1234);
    check("t2_simul_acks", simul, 0);

    // 3: continuous writes from both ports
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'd128; wdata0 = 32'd100;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'd132; wdata1 = 32'd200;
    n = 0; n0 = 0; n1 = 0; simul = 0; first_c = -1; last_c = -1;
    for (int i = 1; i <= 60 && n < 8; i++) begin
      step();
      if (ack0 && ack1) simul++;
      if (ack0 && n < 8) begin
        seq[n] = 0; n++; n0++;
        if (first_c < 0) first_c = i;
        last_c = i;
        if (n0 == 4) req0 = 1'b0; else wdata0 = wdata0 + 1;
      end
      if (ack1 && n < 8) begin
        seq[n] = 1; n++; n1++;
        if (first_c < 0) first_c = i;
        last_c = i;
        if (n1 == 4) req1 = 1'b0; else wdata1 = wdata1 + 1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t3_total", n, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_order%0d", i), seq[i], i % 2);
    check("t3_acks0", n0, 4);
    check("t3_acks1", n1, 4);
    check("t3_span", last_c - first_c, 14);
    check("t3_simul_acks", simul, 0);
    check("t3_mem_last0", mem[32], 103);
    check("t3_mem_last1", mem[33], 203);

    // 4: read timeout on port 1
    no_ack = 1'b1;
    xact(1, 1'b0, 32'd40, 32'd0, lat, rd, er, s1);
    check("t4_lat", lat, 18);
    check("t4_err", er, 1);
    check("t4_rdata1", rd, 0);
    no_ack = 1'b0;
    check("t4_err_cleared", err, 0);
    xact(1, 1'b0, 32'd32, 32'd0, lat, rd, er, s1);
    check("t4_next_lat", lat, 3);
    check("t4_next_data", rd, 1234);
    check("t4_next_err", er, 0);

    // 5: async reset during WAIT_RD
    no_ack = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd16;
    step(); step(); step();
    check("t5_in_wait_addr", mem_addr, 16);
    rst_n = 1'b0;
    #2;
    check("t5_async_zero", any_out(), 0);
    req0 = 1'b0;
    no_ack = 1'b0;
    step();
    rst_n = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack0 || ack1) cnt_a++;
    end
    check("t5_no_spurious_ack", cnt_a, 0);
    xact(0, 1'b0, 32'd16, 32'd0, lat, rd, er, s1);
    check("t5_reissue_lat", lat, 3);
    check("t5_reissue_data", rd, 5678);

    // 6: stale rd_ack in IDLE, then request dropped mid-read
    spur = 1'b1;
    step();
    spur = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0 || ack1 || err) cnt_a++;
    end
    check("t6_stale_ack", cnt_a, 0);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd32;
    step();
    step();
    req0 = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack0) begin
        cnt_a++;
        check("t6_dropped_data", rdata0, 1234);
      end
    end
    check("t6_dropped_acks", cnt_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-ported data_mem.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Serialises one transaction at a time onto the data_mem strobe/write interface and routes the read acknowledge and data back to the winning requester.
- Read timeout guarantees forward progress if data_mem never acknowledges.

Parameters:
ADDR_WIDTH, 32, address width of requesters and memory
DATA_WIDTH, 32, data width
TIMEOUT, 16, cycles in WAIT_RD without i_mem_rd_ack before forced error completion (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock, asynchronous, active-low
i_req0 / i_req1  input  1  request from port 0 / 1; held high until that port's o_ack pulses
i_wr0 / i_wr1  input  1  1 = write, 0 = read; stable while request high
i_addr0 / i_addr1  input  ADDR_WIDTH  byte address
i_wdata0 / i_wdata1  input  DATA_WIDTH  write data
o_ack0 / o_ack1  output  1  one-cycle completion pulse
o_rdata0 / o_rdata1  output  DATA_WIDTH  read data, valid with o_ack, held until that port's next read completes
o_err  output  1  one-cycle pulse with o_ack when a read timed out
o_mem_stb  output  1  read strobe to data_mem (i_stb)
o_mem_wr_en  output  1  write enable to data_mem (i_wr_en)
o_mem_addr  output  ADDR_WIDTH  to data_mem i_addr
o_mem_wdata  output  DATA_WIDTH  to data_mem i_write_data
i_mem_rd_ack  input  1  data_mem o_rd_ack
i_mem_rdata  input  DATA_WIDTH  data_mem o_read_data

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, last_gnt = 1 (so port 0 wins the first tie), timeout counter = 0. All outputs are registered.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one request, grant that port.
  - With both requesting, grant the port other than last_gnt.
  - On grant: latch wr/addr/wdata into internal registers, update last_gnt, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_mem_addr/o_mem_wdata driven from the latched values.
  - Write: o_mem_wr_en = 1, o_mem_stb = 0, o_ackN = 1 in this same cycle (write commits at this edge), next state IDLE.
  - Read: o_mem_stb = 1, o_mem_wr_en = 0, next state WAIT_RD, counter cleared.
- WAIT_RD:
  - o_mem_stb = 0, o_mem_addr held.
  - i_mem_rd_ack = 1: capture i_mem_rdata, go to RESP.
  - Otherwise the counter increments; when it reaches TIMEOUT-1, go to RESP with captured data = 0 and error flag set.
- RESP (1 cycle): o_ackN = 1, o_rdataN = captured data, o_err = error flag, then IDLE.
- Latency from request sampled in IDLE (cycle 0):
  - Write: ack in cycle 1.
  - Read with 1-cycle data_mem: stb in cycle 1, rd_ack in cycle 2, o_ack in cycle 3.
  - Minimum re-arbitration gap is 1 IDLE cycle, so back-to-back writes from one port complete every 2 cycles.
- Fairness: with both ports requesting continuously, grants strictly alternate.
- i_mem_rd_ack seen in IDLE, ISSUE or RESP is ignored (stale ack).
- A request dropped mid-transaction is not aborted: the transaction completes and the ack still pulses.
- Request inputs are only sampled in IDLE. Changes to the losing port's signals never affect the active transaction.
- o_ack0 and o_ack1 are never high in the same cycle. o_mem_stb and o_mem_wr_en are never high in the same cycle.
- Asynchronous reset mid-operation: immediately forces IDLE and all outputs to 0. The in-flight transaction is dropped and the requester must reissue. A write already issued in ISSUE has committed.
- Counter width is clog2(TIMEOUT). It does not wrap; it saturates at TIMEOUT-1.

Test Plan:
1. Port 0 write addr 32, data 1234, then port 0 read addr 32, with a behavioural 1-cycle data_mem model → write: o_mem_wr_en pulse in cycle 1 and o_ack0 in cycle 1; read: o_ack0 in cycle 3 with o_rdata0 = 1234, o_err = 0.
2. Both ports request reads in the same cycle after reset (port 0 addr 16, port 1 addr 32, preloaded 5678 / 1234) → port 0 is served first (o_rdata0 = 5678), then port 1 (o_rdata1 = 1234); acks are never simultaneous.
3. Both ports issue continuous writes for 8 transactions → grant order 0,1,0,1,…; each port receives exactly 4 acks.
4. Memory model never asserts rd_ack, TIMEOUT = 16 → o_ack1 and o_err pulse together exactly 16 cycles after WAIT_RD entry; o_rdata1 = 0; the next request is served normally.
5. rst_n pulled low during WAIT_RD of a port 0 read → all outputs 0 asynchronously; after release, no spurious o_ack0; a reissued read returns correct data.
6. Spurious i_mem_rd_ack while IDLE, and port 0 dropping i_req0 during WAIT_RD → no ack generated from the spurious pulse; the dropped read still completes with a single o_ack0.
